guffin_coin_fsm: RTL and testbench
==================================

Name: guffin_coin_fsm

Overview:
- Coin-acceptor front end of the guffin vending path; produces the one-hot credit state cState_0..cState_6 consumed by the output/change decoder.
- Synchronises and edge-detects coin inputs and accumulates credit in quarter units.
- Holds a vend state until dispense completes, then reloads the retained credit that the decoder reports back on stateOut_1/stateOut_0.

Parameters:
- PRICE, 3, guffin price in quarters; legal range 1..3, so the maximum credit PRICE-1+4 stays at or below 6.
- SYNC_STAGES, 2, synchroniser depth on the coin inputs; legal value 2 or 3.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- coin_quarter  input  1  asynchronous level from coin mech; a rising edge is one quarter (1 unit).
- coin_half  input  1  asynchronous level; a rising edge is a half dollar (2 units).
- coin_dollar  input  1  asynchronous level; a rising edge is a dollar (4 units).
- stateOut_0  input  1  retained-credit bit 0 from the decoder; weight 1 quarter.
- stateOut_1  input  1  retained-credit bit 1 from the decoder; weight 2 quarters.
- dispense_done  input  1  single-cycle pulse from the dispenser; guffin and change have been delivered.
- cState_0..cState_6  output  1 each  registered one-hot of the credit register (0..6 quarters).
- busy  output  1  high while in VEND; coins are not accepted.
- coin_reject  output  1  one-cycle pulse when a coin event is discarded.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - credit=0, state=IDLE, cState_0=1, all other cState=0.
  - busy=0, coin_reject=0, synchroniser and edge flops cleared.
  - Reset mid-VEND abandons the vend; credit is lost.
- Synchronisation:
  - Each coin line passes through a SYNC_STAGES flop chain plus one history flop.
  - An event is detected when the synchronised value is 1 and the history value is 0.
- Latency (SYNC_STAGES=2):
  - A coin level first sampled high at edge E is seen by the credit register after edge E+2.
  - cState reflects the new credit in the cycle following E+2.
- Credit register: 3 bits, unsigned. cState_k = (credit==k). Exactly one cState is high in every cycle after reset.
- States:
  - IDLE (credit=0): a valid coin event sets credit=coin value, then goes to ACCUM or VEND.
  - ACCUM (0<credit<PRICE): a valid coin event sets credit=credit+value. Result >= PRICE goes to VEND, otherwise stays in ACCUM.
  - VEND (credit>=PRICE):
    - busy=1 and credit is held constant, so the decoder sees a stable cState_k.
    - Any coin event in VEND is discarded and coin_reject pulses.
    - On dispense_done: credit={stateOut_1,stateOut_0} sampled that cycle, busy=0 next cycle.
    - Next state is IDLE if the loaded value is 0, ACCUM if it is 1..PRICE-1, and VEND again if it is >= PRICE.
- Simultaneous events:
  - Coin events on two or more lines in the same cycle: all are discarded, coin_reject=1, credit unchanged.
  - A coin event and dispense_done in the same VEND cycle: the coin is rejected and the reload proceeds.
- dispense_done outside VEND is ignored.
- Arithmetic: credit+value never exceeds 6 for legal PRICE. No wrap; if it would exceed 6, the coin is rejected (defensive only).
- A held coin level produces exactly one event. A new event needs the level to fall and rise again.

Test Plan:
- Reset then idle 10 cycles -> cState_0=1, busy=0, coin_reject=0 throughout.
- coin_quarter pulse at edge E -> cState_1=1 from cycle after E+2. Second quarter -> cState_2. Third -> cState_3 and busy=1.
- coin_half then coin_dollar (separated) -> cState_2, then cState_6 with busy=1. Apply stateOut_1=1, stateOut_0=1 and dispense_done -> next cycle cState_3, busy stays 1 (re-vend).
- In VEND, pulse coin_quarter -> coin_reject pulses once, cState unchanged. Then dispense_done with stateOut=00 -> cState_0, busy=0.
- coin_quarter and coin_half rise in the same cycle from credit 1 -> coin_reject pulse, cState_1 retained. Holding coin_quarter high 20 cycles -> exactly one increment.
- Assert rst_n=0 asynchronously mid-VEND at credit 4 -> outputs go to cState_0=1, busy=0 without waiting for clk. dispense_done after reset is ignored.

Source files
------------

// File: rtl/guffin_coin_if.sv
// Coin-acceptor bus for guffin_coin_fsm: coin levels, decoder feedback,
// dispenser handshake, and the one-hot credit state going back out.
interface guffin_coin_if;
  logic coin_quarter;
  logic coin_half;
  logic coin_dollar;
  logic stateOut_0;
  logic stateOut_1;
  logic dispense_done;
  logic cState_0;
  logic cState_1;
  logic cState_2;
  logic cState_3;
  logic cState_4;
  logic cState_5;
  logic cState_6;
  logic busy;
  logic coin_reject;

  modport master (
    output coin_quarter, coin_half, coin_dollar,
    output stateOut_0, stateOut_1, dispense_done,
    input  cState_0, cState_1, cState_2, cState_3, cState_4, cState_5, cState_6,
    input  busy, coin_reject
  );

  modport slave (
    input  coin_quarter, coin_half, coin_dollar,
    input  stateOut_0, stateOut_1, dispense_done,
    output cState_0, cState_1, cState_2, cState_3, cState_4, cState_5, cState_6,
    output busy, coin_reject
  );
endinterface

// File: rtl/guffin_coin_fsm.sv
// Guffin coin acceptor: synchronises and edge-detects coins, accumulates credit
// in quarters, and holds VEND until the dispenser reports done.
module guffin_coin_fsm #(
  parameter int PRICE       = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst_n,
  guffin_coin_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, VEND} state_t;

  state_t      state, state_next;
  logic [2:0]  credit, credit_next;
  logic [6:0]  cstate;
  logic        reject, reject_next;

  // Bit order in every coin vector: [2]=dollar, [1]=half, [0]=quarter.
  logic [2:0]  sync_q [SYNC_STAGES];
  logic [2:0]  hist_q;
  logic [2:0]  synced;
  logic [2:0]  ev;
  logic        multi;
  logic [3:0]  value;
  logic [3:0]  sum;
  logic [3:0]  reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= {bus.coin_dollar, bus.coin_half, bus.coin_quarter};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign ev     = synced & ~hist_q;
  assign multi  = (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);
  assign value  = ev[2] ? 4'd4 : (ev[1] ? 4'd2 : 4'd1);
  assign sum    = {1'b0, credit} + value;
  assign reload = {2'b00, bus.stateOut_1, bus.stateOut_0};

  function automatic state_t classify(input logic [3:0] c);
    if (c == 4'd0)
      return IDLE;
    else if (c < 4'(PRICE))
      return ACCUM;
    else
      return VEND;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      credit <= 3'd0;
      cstate <= 7'd1;
      reject <= 1'b0;
    end else begin
      state  <= state_next;
      credit <= credit_next;
      cstate <= 7'd1 << credit_next;
      reject <= reject_next;
    end
  end

  // Coins are only credited one at a time; anything ambiguous is rejected.
  always_comb begin
    state_next  = state;
    credit_next = credit;
    reject_next = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (multi) begin
          reject_next = 1'b1;
        end else if (|ev) begin
          if (sum > 4'd6) begin
            reject_next = 1'b1;
          end else begin
            credit_next = sum[2:0];
            state_next  = classify(sum);
          end
        end
      end
      VEND: begin
        if (|ev) reject_next = 1'b1;
        if (bus.dispense_done) begin
          credit_next = reload[2:0];
          state_next  = classify(reload);
        end
      end
      default: begin
        state_next  = IDLE;
        credit_next = 3'd0;
      end
    endcase
  end

  assign bus.cState_0    = cstate[0];
  assign bus.cState_1    = cstate[1];
  assign bus.cState_2    = cstate[2];
  assign bus.cState_3    = cstate[3];
  assign bus.cState_4    = cstate[4];
  assign bus.cState_5    = cstate[5];
  assign bus.cState_6    = cstate[6];
  assign bus.busy        = (state == VEND);
  assign bus.coin_reject = reject;

endmodule

// File: tb/tb_guffin_coin_fsm.sv
// Self-checking bench for guffin_coin_fsm: directed vector table, hand-written
// corner sequences, and random stimulus against a credit-level reference model.
module tb_guffin_coin_fsm;
  localparam int PRICE = 3;
  localparam int SYNC  = 2;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  guffin_coin_if ifc ();

  guffin_coin_fsm #(.PRICE(PRICE), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] cstate_vec;
  assign cstate_vec = {ifc.cState_6, ifc.cState_5, ifc.cState_4, ifc.cState_3,
                       ifc.cState_2, ifc.cState_1, ifc.cState_0};

  // Reference: a coin counts once its level, SYNC cycles old, is new relative
  // to the cycle before; credit is an integer checked against the price rules.
  int       m_credit;
  bit       m_reject;
  bit [4:0] lq, lh, ld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_credit = 0;
      m_reject = 0;
      lq = '0; lh = '0; ld = '0;
    end else begin
      int n, val;
      bit eq, eh, ed;
      lq = {lq[3:0], ifc.coin_quarter};
      lh = {lh[3:0], ifc.coin_half};
      ld = {ld[3:0], ifc.coin_dollar};
      eq = lq[SYNC] && !lq[SYNC+1];
      eh = lh[SYNC] && !lh[SYNC+1];
      ed = ld[SYNC] && !ld[SYNC+1];
      n   = int'(eq) + int'(eh) + int'(ed);
      val = int'(eq) * 1 + int'(eh) * 2 + int'(ed) * 4;
      m_reject = 0;
      if (m_credit >= PRICE) begin
        m_reject = (n > 0);
        if (ifc.dispense_done)
          m_credit = int'(ifc.stateOut_1) * 2 + int'(ifc.stateOut_0);
      end else if (n > 1) begin
        m_reject = 1;
      end else if (n == 1) begin
        if (m_credit + val > 6) m_reject = 1;
        else m_credit = m_credit + val;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic q, input logic h, input logic d,
                                input logic done, input logic [1:0] so);
    ifc.coin_quarter  = q;
    ifc.coin_half     = h;
    ifc.coin_dollar   = d;
    ifc.dispense_done = done;
    ifc.stateOut_1    = so[1];
    ifc.stateOut_0    = so[0];
    step();
  endtask

  task automatic check_output(input string name, input logic [6:0] exp_c,
                              input logic exp_b, input logic exp_r);
    n_compared++;
    if ({cstate_vec, ifc.busy, ifc.coin_reject} !== {exp_c, exp_b, exp_r}) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got cstate=%b busy=%b reject=%b, expected cstate=%b busy=%b reject=%b",
               name, cstate_vec, ifc.busy, ifc.coin_reject, exp_c, exp_b, exp_r);
    end
  endtask

  typedef struct {
    logic       q, h, d, done;
    logic [1:0] so;
    logic [6:0] c;
    logic       b, r;
  } vec_t;

  vec_t tbl [19];

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    // Expected values listed after the clock edge that follows each input.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0000001, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0000001, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0000010, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0000010, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 7'b0000010, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0000010, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0001000, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0001000, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0001000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0001000, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0001000, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 7'b0000010, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0000010, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 7'b0000010, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0000010, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0100000, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 7'b0001000, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 7'b0000001, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 7'b0000001, 1'b0, 1'b0};

    rst_n = 1'b0;
    ifc.coin_quarter = 0; ifc.coin_half = 0; ifc.coin_dollar = 0;
    ifc.dispense_done = 0; ifc.stateOut_0 = 0; ifc.stateOut_1 = 0;
    step();
    step();
    check_output("reset_state", 7'b0000001, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, 0, 0, 0, 2'b00);
      check_output("idle_after_reset", 7'b0000001, 1'b0, 1'b0);
    end

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(tbl[i].q, tbl[i].h, tbl[i].d, tbl[i].done, tbl[i].so);
      check_output($sformatf("table_%0d", i), tbl[i].c, tbl[i].b, tbl[i].r);
    end

    apply_stimulus(1, 0, 0, 0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 2'b00);
    check_output("quarter_to_1", 7'b0000010, 1'b0, 1'b0);

    // Two lines rising together must be thrown away as a pair.
    apply_stimulus(1, 1, 0, 0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 2'b00);
    check_output("simultaneous_reject", 7'b0000010, 1'b0, 1'b1);
    apply_stimulus(0, 0, 0, 0, 2'b00);
    check_output("simultaneous_after", 7'b0000010, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1, 0, 0, 0, 2'b00);
      if (i < 2) check_output("held_quarter_pre", 7'b0000010, 1'b0, 1'b0);
      else       check_output("held_quarter_once", 7'b0000100, 1'b0, 1'b0);
    end
    apply_stimulus(0, 0, 0, 0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 2'b00);
    check_output("held_quarter_release", 7'b0000100, 1'b0, 1'b0);

    apply_stimulus(1, 0, 0, 0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 2'b00);
    check_output("third_quarter_vend", 7'b0001000, 1'b1, 1'b0);
    apply_stimulus(0, 0, 0, 1, 2'b00);
    check_output("vend_to_idle", 7'b0000001, 1'b0, 1'b0);

    apply_stimulus(0, 0, 1, 0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 2'b00);
    apply_stimulus(0, 0, 0, 0, 2'b00);
    check_output("dollar_vend_4", 7'b0010000, 1'b1, 1'b0);
    #4;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_mid_vend", 7'b0000001, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    apply_stimulus(0, 0, 0, 1, 2'b11);
    check_output("done_after_reset_ignored", 7'b0000001, 1'b0, 1'b0);
    apply_stimulus(0, 0, 0, 0, 2'b00);

    for (int i = 0; i < 600; i++) begin
      logic q, h, d, done;
      logic [1:0] so;
      q    = ($urandom_range(0, 5) == 0) ? ~ifc.coin_quarter : ifc.coin_quarter;
      h    = ($urandom_range(0, 7) == 0) ? ~ifc.coin_half    : ifc.coin_half;
      d    = ($urandom_range(0, 9) == 0) ? ~ifc.coin_dollar  : ifc.coin_dollar;
      done = ($urandom_range(0, 4) == 0);
      so   = 2'($urandom_range(0, 3));
      apply_stimulus(q, h, d, done, so);
      check_output("random_vs_model", 7'(7'd1 << m_credit), (m_credit >= PRICE), m_reject);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
